// File: rtl/quant_pkg.sv
// Shared rounding-mode encoding and default Q-format widths for the requantizer.
package quant_pkg;

  typedef logic [1:0] rnd_mode_t;

  localparam rnd_mode_t RND_TRUNC     = 2'd0;
  localparam rnd_mode_t RND_HALF_UP   = 2'd1;
  localparam rnd_mode_t RND_HALF_EVEN = 2'd2;

  // Q6.26 accumulator in, Q4.12 activation out
  localparam int DEF_IN_W     = 32;
  localparam int DEF_IN_FRAC  = 26;
  localparam int DEF_OUT_W    = 16;
  localparam int DEF_OUT_FRAC = 12;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/quant_round_sat.sv
// Combinational requantizer core: rounding add (stage-1 half) and
// arithmetic shift with clamp (stage-2 half), split so the caller can register between them.
module quant_round_sat
  import quant_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input  logic signed [IN_W-1:0]  i_data,
  input  rnd_mode_t               i_mode,
  output logic signed [IN_W:0]    o_sum,
  input  logic signed [IN_W:0]    i_sum,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int HI_W  = IN_W - OUT_W + 2;

  // One guard bit above IN_W keeps a round-up of the largest input from wrapping negative.
  function automatic logic signed [IN_W:0] round_add(input logic signed [IN_W-1:0] d,
                                                     input rnd_mode_t m);
    logic [IN_W:0] half;
    logic [IN_W:0] inc;
    half           = '0;
    half[SHIFT-1]  = 1'b1;
    case (m)
      RND_HALF_UP:   inc = half;
      RND_HALF_EVEN: inc = half - 1'b1 + {{IN_W{1'b0}}, d[SHIFT]};
      default:       inc = '0;
    endcase
    return $signed({d[IN_W-1], d}) + $signed(inc);
  endfunction

  // Returns {sat, data}; in range when every bit from OUT_W-1 upward matches the sign.
  function automatic logic [OUT_W:0] shift_sat(input logic signed [IN_W:0] s);
    logic signed [IN_W:0] sh;
    logic [HI_W-1:0]      hi;
    sh = s >>> SHIFT;
    hi = sh[IN_W:OUT_W-1];
    if ((&hi) || !(|hi))
      return {1'b0, sh[OUT_W-1:0]};
    else if (sh[IN_W])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign o_sum           = round_add(i_data, i_mode);
  assign {o_sat, o_data} = shift_sat(i_sum);

endmodule

// File: rtl/quantizer_param.sv
// Two-stage pipelined requantizer with valid/ready handshake and saturation flags.
// Define QUANTIZER_SAT_COUNT_EN to build the o_sat_cnt saturation event counter.
module quantizer_param
  import quant_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_FRAC = DEF_OUT_FRAC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [IN_W-1:0]  i_data,
  input  rnd_mode_t               i_mode,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat,
  output logic                    o_sat_sticky,
  input  logic                    i_clr_sticky
`ifdef QUANTIZER_SAT_COUNT_EN
  ,
  output logic [CNT_W-1:0]        o_sat_cnt
`endif
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;

  if (SHIFT < 1 || OUT_W + SHIFT > IN_W || CNT_W < 1) begin : g_bad_params
    $error("quantizer_param: illegal IN/OUT format or CNT_W");
  end

  logic                    en;
  logic signed [IN_W:0]    sum_c;
  logic signed [OUT_W-1:0] q_c;
  logic                    sat_c;

  logic                    vld_p1;
  logic signed [IN_W:0]    sum_p1;
  logic                    vld_p2;
  logic signed [OUT_W-1:0] data_p2;
  logic                    sat_p2;
  logic                    sticky_q;

  assign en      = i_ready | ~vld_p2;
  assign o_ready = en;

  quant_round_sat #(
    .IN_W     (IN_W),
    .IN_FRAC  (IN_FRAC),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC)
  ) u_round_sat (
    .i_data (i_data),
    .i_mode (i_mode),
    .o_sum  (sum_c),
    .i_sum  (sum_p1),
    .o_data (q_c),
    .o_sat  (sat_c)
  );

  // Stage 1: rounding increment applied
  always_ff @(posedge clk) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (en && i_valid) sum_p1 <= sum_c;
  end

  // Stage 2: shifted and clamped output word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= q_c;
        sat_p2  <= sat_c;
      end else begin
        sat_p2  <= 1'b0;
      end
    end
  end

  // A clamp entering stage 2 outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                          sticky_q <= 1'b0;
    else if (en && vld_p1 && sat_c)   sticky_q <= 1'b1;
    else if (i_clr_sticky)            sticky_q <= 1'b0;
  end

  assign o_valid      = vld_p2;
  assign o_data       = data_p2;
  assign o_sat        = sat_p2;
  assign o_sat_sticky = sticky_q;

`ifdef QUANTIZER_SAT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  assign cnt_inc = vld_p2 & i_ready & sat_p2;

  // Counts delivered clamped beats, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (i_clr_sticky)            cnt_q <= {{(CNT_W-1){1'b0}}, cnt_inc};
    else if (cnt_inc && !(&cnt_q))    cnt_q <= cnt_q + 1'b1;
  end

  assign o_sat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_quantizer_param.sv
// Bench for quantizer_param at default widths: vector table, latency, stall, flags, reset.
module tb_quantizer_param;
  import quant_pkg::*;

  typedef struct {
    logic [31:0] d;
    rnd_mode_t   m;
    logic [15:0] q;
    logic        s;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_clr_sticky = 1'b0;
  logic [31:0] i_data = '0;
  rnd_mode_t   i_mode = RND_TRUNC;
  logic        o_ready, o_valid, o_sat, o_sat_sticky;
  logic [15:0] o_data;
`ifdef QUANTIZER_SAT_COUNT_EN
  logic [15:0] o_sat_cnt;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_deliv = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[16];

  quantizer_param dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_mode       (i_mode),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_sat        (o_sat),
    .o_sat_sticky (o_sat_sticky),
    .i_clr_sticky (i_clr_sticky)
`ifdef QUANTIZER_SAT_COUNT_EN
    ,
    .o_sat_cnt    (o_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: floor division by 2^14 with explicit remainder tests, then clamp.
  function automatic exp_t ref_q(input logic [31:0] d, input rnd_mode_t m);
    longint v, q, r;
    exp_t   e;
    v = longint'($signed(d));
    q = v >>> 14;
    r = v - q * 16384;
    if (m == RND_HALF_UP && r >= 8192) q = q + 1;
    else if (m == RND_HALF_EVEN && (r > 8192 || (r == 8192 && q[0]))) q = q + 1;
    if (q > 32767)       begin e.q = 16'h7FFF; e.s = 1'b1; end
    else if (q < -32768) begin e.q = 16'h8000; e.s = 1'b1; end
    else                 begin e.q = q[15:0];  e.s = 1'b0; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      n_deliv++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data=%h sat=%b, expected no beat", o_data, o_sat);
      end else begin
        mon_e = sb.pop_front();
        check("beat_data", {16'h0, o_data}, {16'h0, mon_e.q});
        check("beat_sat", {31'h0, o_sat}, {31'h0, mon_e.s});
      end
    end
  end

  task automatic send(input logic [31:0] d, input rnd_mode_t m, input logic [15:0] q, input logic s);
    bit done = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        sb.push_back('{q, s});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got o_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic send_m(input logic [31:0] d, input rnd_mode_t m);
    exp_t e;
    e = ref_q(d, m);
    send(d, m, e.q, e.s);
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int   base;
    logic [15:0] held;

    vecs[0]  = '{32'h0000_2000, RND_TRUNC,     16'h0000, 1'b0};
    vecs[1]  = '{32'h0000_2000, RND_HALF_UP,   16'h0001, 1'b0};
    vecs[2]  = '{32'h0000_2000, RND_HALF_EVEN, 16'h0000, 1'b0};
    vecs[3]  = '{32'h0000_6000, RND_HALF_EVEN, 16'h0002, 1'b0};
    vecs[4]  = '{32'hFFFF_E000, RND_TRUNC,     16'hFFFF, 1'b0};
    vecs[5]  = '{32'hFFFF_E000, RND_HALF_UP,   16'h0000, 1'b0};
    vecs[6]  = '{32'hFFFF_E000, RND_HALF_EVEN, 16'h0000, 1'b0};
    vecs[7]  = '{32'h2000_0000, RND_TRUNC,     16'h7FFF, 1'b1};
    vecs[8]  = '{32'hE000_0000, RND_TRUNC,     16'h8000, 1'b0};
    vecs[9]  = '{32'hC000_0000, RND_TRUNC,     16'h8000, 1'b1};
    vecs[10] = '{32'h1FFF_FFFF, RND_TRUNC,     16'h7FFF, 1'b0};
    vecs[11] = '{32'h1FFF_FFFF, RND_HALF_UP,   16'h7FFF, 1'b1};
    vecs[12] = '{32'h7FFF_FFFF, RND_HALF_UP,   16'h7FFF, 1'b1};
    vecs[13] = '{32'hFFFF_A000, RND_HALF_EVEN, 16'hFFFE, 1'b0};
    vecs[14] = '{32'hFFFF_A000, RND_HALF_UP,   16'hFFFF, 1'b0};
    vecs[15] = '{32'h0000_2000, 2'd3,          16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid",  {31'h0, o_valid},      32'h0);
    check("rst_data",   {16'h0, o_data},       32'h0);
    check("rst_sat",    {31'h0, o_sat},        32'h0);
    check("rst_sticky", {31'h0, o_sat_sticky}, 32'h0);
    check("rst_ready",  {31'h0, o_ready},      32'h1);
`ifdef QUANTIZER_SAT_COUNT_EN
    check("rst_cnt",    {16'h0, o_sat_cnt},    32'h0);
`endif
    @(posedge clk); #1;

    // Latency: 1.0 accepted at one edge appears two cycles later.
    i_valid = 1'b1; i_data = 32'h0400_0000; i_mode = RND_TRUNC;
    @(negedge clk);
    check("lat_ready", {31'h0, o_ready}, 32'h1);
    sb.push_back('{16'h1000, 1'b0});
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", {31'h0, o_valid}, 32'h0);
    @(negedge clk);
    check("lat_c2_valid", {31'h0, o_valid}, 32'h1);
    check("lat_c2_data",  {16'h0, o_data},  32'h0000_1000);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 16; i++) send(vecs[i].d, vecs[i].m, vecs[i].q, vecs[i].s);
    drain();

    // Backpressure: 8 beats with a 3-cycle downstream stall.
    base = n_deliv;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_m((i % 3 == 0) ? {3'b001, 29'($urandom)} : $urandom, rnd_mode_t'($urandom_range(0, 3)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        @(negedge clk);
        held = o_data;
        check("stall_ready", {31'h0, o_ready}, 32'h0);
        check("stall_valid", {31'h0, o_valid}, 32'h1);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("stall_ready", {31'h0, o_ready}, 32'h0);
          check("stall_data",  {16'h0, o_data},  {16'h0, held});
        end
        @(posedge clk); #1 i_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_deliv - base, 32'd8);

    // Sticky flag and counter.
    i_clr_sticky = 1'b1;
    @(posedge clk); #1 i_clr_sticky = 1'b0;
    check("clr_sticky", {31'h0, o_sat_sticky}, 32'h0);
`ifdef QUANTIZER_SAT_COUNT_EN
    check("clr_cnt", {16'h0, o_sat_cnt}, 32'h0);
`endif
    send(32'hE000_0000, RND_TRUNC, 16'h8000, 1'b0);
    drain();
    check("min_no_sticky", {31'h0, o_sat_sticky}, 32'h0);
    for (int i = 0; i < 3; i++) send(32'h2000_0000, RND_TRUNC, 16'h7FFF, 1'b1);
    drain();
    check("sticky_set", {31'h0, o_sat_sticky}, 32'h1);
`ifdef QUANTIZER_SAT_COUNT_EN
    check("cnt_3", {16'h0, o_sat_cnt}, 32'h3);
`endif
    send(32'hC000_0000, RND_TRUNC, 16'h8000, 1'b1);
    i_clr_sticky = 1'b1;
    @(posedge clk); #1 i_clr_sticky = 1'b0;
    check("sticky_set_wins", {31'h0, o_sat_sticky}, 32'h1);
    drain();
`ifdef QUANTIZER_SAT_COUNT_EN
    check("cnt_after_clr", {16'h0, o_sat_cnt}, 32'h1);
`endif

    // Reset with two beats in flight.
    send(32'h2000_0000, RND_TRUNC, 16'h7FFF, 1'b1);
    send(32'h0400_0000, RND_TRUNC, 16'h1000, 1'b0);
    rst = 1'b1;
    sb.delete();
    base = n_deliv;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",  {31'h0, o_valid},      32'h0);
    check("mid_rst_sat",    {31'h0, o_sat},        32'h0);
    check("mid_rst_sticky", {31'h0, o_sat_sticky}, 32'h0);
    check("mid_rst_data",   {16'h0, o_data},       32'h0);
`ifdef QUANTIZER_SAT_COUNT_EN
    check("mid_rst_cnt",    {16'h0, o_sat_cnt},    32'h0);
`endif
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_beats", n_deliv - base, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
